s_d: RTL and testbench
======================

Name: s_d

Overview:
- Sequential restoring divider; the inverse operation of the team's sequential multiplier.
- Divides a 2N-bit dividend `a` by an N-bit divisor `b` using one shift/subtract iteration per clock.
- Produces a 2N-bit quotient `Q` and an N-bit remainder `R`.
- Has a start/busy/done handshake so the datapath can issue operations without pulsing reset per operand.

Parameters:
- N, 4, divisor/remainder width; dividend and quotient are 2N bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  2N  dividend (unsigned), captured on accepted start
- b  input  N  divisor (unsigned), captured on accepted start
- Q  output  2N  quotient; holds last result
- R  output  N  remainder; holds last result
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse: Q/R/dz valid and just updated
- dz  output  1  divide-by-zero flag for last result; holds until the next result

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
  - While rst=1: state=IDLE; Q=0, R=0, busy=0, done=0, dz=0; working registers and iteration counter=0.
  - Reset mid-operation aborts the operation immediately; no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k with b!=0: latch a into dividend shift reg and b into divisor reg; partial remainder (N+1 bits)=0; cnt=0; go to RUN.
  - start=1 at edge k with b==0: go directly to DONE; Q=all ones, R=0, dz=1.
  - start=0: stay in IDLE.
- RUN (busy=1): each edge performs one iteration, then cnt++.
  - Form rem' = {rem[N-1:0], dividend MSB}; shift the dividend left by 1.
  - If rem' >= divisor: rem = rem' - divisor and shift in quotient bit 1; else rem = rem' and shift in quotient bit 0.
  - After 2N iterations (edge k+2N): load Q and R from the working registers, dz=0, go to DONE.
- DONE (done=1, busy=0): lasts exactly one cycle, then IDLE.
- Latency:
  - Normal: start edge k to done high after edge k+2N (8 cycles for N=4).
  - Divide-by-zero: done high after edge k (1 cycle).
- Q and R come from separate output registers and never show partial results during RUN. They change only at the DONE transition or on reset.
- start in RUN or DONE is ignored; it is not queued. Operands changing during RUN have no effect.
- The earliest back-to-back start is the IDLE cycle after done, i.e. one operation per 2N+2 cycles.
- Arithmetic: unsigned only. The trial subtraction is N+1 bits wide, so there is no overflow.
  - Result invariant: a == Q*b + R and R < b, for every a in [0, 2^(2N)-1] and b in [1, 2^N-1].
  - The quotient can reach 2^(2N)-1 (e.g. b=1); no saturation occurs.

Test Plan:
- Reset, then start with a=200, b=7 -> busy for 8 cycles; done pulse 8 cycles after the start edge; Q=28, R=4, dz=0; Q/R hold after done falls.
- Boundary values, each started from IDLE:
  - a=255, b=1 -> Q=255, R=0
  - a=9, b=10 -> Q=0, R=9
  - a=15, b=15 -> Q=1, R=0
  - a=0, b=3 -> Q=0, R=0
- a=100, b=0 -> done one cycle after the start edge, busy never asserted; Q=255, R=0, dz=1. A following a=50, b=5 -> Q=10, R=0, dz=0.
- start a=200, b=7; at RUN iteration 3, pulse start with a=10, b=2 and change a/b -> pulses ignored; result is still Q=28, R=4; exactly one done.
- start a=200, b=7; assert rst asynchronously mid-edge at iteration 4 -> Q, R, busy, done, dz drop to 0 without waiting for a clock; no done after release; a fresh start a=77, b=6 -> Q=12, R=5.
- Exhaustive sweep, b in 1..15 and a in 0..255 issued back-to-back on each IDLE, mirroring the multiplier bench's operand sweep -> every result satisfies a==Q*b+R and R<b; done count equals issue count.

Source files
------------

// File: rtl/s_d_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface s_d_if #(
  parameter int unsigned N = 4
);
  logic             start;
  logic [2*N-1:0]   a;
  logic [N-1:0]     b;
  logic [2*N-1:0]   Q;
  logic [N-1:0]     R;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (output start, a, b, input Q, R, busy, done, dz);
  modport slave  (input start, a, b, output Q, R, busy, done, dz);
endinterface

// File: rtl/s_d.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one shift/subtract per clock.
module s_d #(
  parameter int unsigned N = 4
) (
  input  logic   clk,
  input  logic   rst,
  s_d_if.slave   bus
);
  localparam int unsigned DW = 2 * N;
  localparam int unsigned RW = N + 1;
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [DW-1:0] dvd, dvd_d;
  logic [N-1:0]  dvs, dvs_d;
  logic [N-1:0]  rem, rem_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [DW-1:0] q_r, q_d;
  logic [N-1:0]  r_r, r_d;
  logic          dz_r, dz_d;
  logic          busy_r, done_r;
  logic [RW-1:0] rem_sub;
  logic [N-1:0]  rem_lo;
  logic          qbit;

  // Next-state, working-register and result update
  always_comb begin
    state_d = state;
    dvd_d   = dvd;
    dvs_d   = dvs;
    rem_d   = rem;
    cnt_d   = cnt;
    q_d     = q_r;
    r_d     = r_r;
    dz_d    = dz_r;
    // Remainder stays below the divisor, so the borrow bit alone decides the quotient bit
    rem_sub = {rem, dvd[DW-1]} - {1'b0, dvs};
    rem_lo  = {rem[N-2:0], dvd[DW-1]};
    qbit    = ~rem_sub[RW-1];
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.b != '0) begin
            dvd_d   = bus.a;
            dvs_d   = bus.b;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            q_d     = '1;
            r_d     = '0;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        rem_d = qbit ? rem_sub[N-1:0] : rem_lo;
        dvd_d = {dvd[DW-2:0], qbit};
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(DW - 1)) begin
          q_d     = dvd_d;
          r_d     = rem_d;
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      q_r    <= '0;
      r_r    <= '0;
      dz_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_d;
      dvd    <= dvd_d;
      dvs    <= dvs_d;
      rem    <= rem_d;
      cnt    <= cnt_d;
      q_r    <= q_d;
      r_r    <= r_d;
      dz_r   <= dz_d;
      busy_r <= (state_d == RUN);
      done_r <= (state_d == DONE);
    end
  end

  assign bus.Q    = q_r;
  assign bus.R    = r_r;
  assign bus.dz   = dz_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule

// File: tb/tb_s_d.sv
// Self-checking bench for s_d: directed vector table, corner sequences, random ops and an operand sweep.
module tb_s_d;
  localparam int unsigned N  = 4;
  localparam int          LAT_NORM = 2 * N;
  localparam int          BOUND = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  s_d_if #(.N(N)) bus ();
  s_d #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issue one operation from IDLE; returns results at the negedge where done is seen
  task automatic run_op(input int av, input int bv, output int q, output int r,
                        output int dz, output int lat, output int busyc);
    logic [2*N-1:0] a_l;
    logic [N-1:0]   b_l;
    a_l = av[2*N-1:0];
    b_l = bv[N-1:0];
    @(posedge clk);
    #1;
    bus.a = a_l;
    bus.b = b_l;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    busyc = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && lat < BOUND) begin
      if (bus.busy === 1'b1) busyc++;
      @(negedge clk);
      lat++;
    end
    q  = int'(bus.Q);
    r  = int'(bus.R);
    dz = int'(bus.dz);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, r, dz, lat, busyc, d0, av, bv, eq, er, edz, ok;

    vecs[0] = '{a: 200, b: 7,  q: 28,  r: 4, dz: 0, lat: LAT_NORM};
    vecs[1] = '{a: 255, b: 1,  q: 255, r: 0, dz: 0, lat: LAT_NORM};
    vecs[2] = '{a: 9,   b: 10, q: 0,   r: 9, dz: 0, lat: LAT_NORM};
    vecs[3] = '{a: 15,  b: 15, q: 1,   r: 0, dz: 0, lat: LAT_NORM};
    vecs[4] = '{a: 0,   b: 3,  q: 0,   r: 0, dz: 0, lat: LAT_NORM};
    vecs[5] = '{a: 100, b: 0,  q: 255, r: 0, dz: 1, lat: 0};
    vecs[6] = '{a: 50,  b: 5,  q: 10,  r: 0, dz: 0, lat: LAT_NORM};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_Q", int'(bus.Q), 0);
    chk("reset_R", int'(bus.R), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_dz", int'(bus.dz), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, r, dz, lat, busyc);
      chk($sformatf("vec%0d_Q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_R", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busycycles", i), busyc, vecs[i].lat);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), int'(bus.done), 0);
      chk($sformatf("vec%0d_Q_hold", i), int'(bus.Q), vecs[i].q);
      chk($sformatf("vec%0d_R_hold", i), int'(bus.R), vecs[i].r);
    end

    // start pulsed mid-run with new operands must be ignored
    @(posedge clk);
    #1;
    bus.a = 8'd200;
    bus.b = 4'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 8'd10;
    bus.b = 4'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 8'd33;
    bus.b = 4'd9;
    wait_done(lat);
    chk("ignore_Q", int'(bus.Q), 28);
    chk("ignore_R", int'(bus.R), 4);
    chk("ignore_lat", lat, LAT_NORM - 3);
    repeat (12) @(negedge clk);
    chk("ignore_done_count", done_cnt - d0, 1);

    // asynchronous reset in the middle of a run
    @(posedge clk);
    #1;
    bus.a = 8'd200;
    bus.b = 4'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_Q", int'(bus.Q), 0);
    chk("abort_R", int'(bus.R), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_dz", int'(bus.dz), 0);
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_op(77, 6, q, r, dz, lat, busyc);
    chk("after_abort_Q", q, 12);
    chk("after_abort_R", r, 5);
    chk("after_abort_dz", dz, 0);

    // random operands against an arithmetic reference
    for (int i = 0; i < 60; i++) begin
      av = int'($urandom_range(0, 255));
      bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      if (bv == 0) begin
        eq = 255; er = 0; edz = 1;
      end else begin
        eq = av / bv; er = av % bv; edz = 0;
      end
      run_op(av, bv, q, r, dz, lat, busyc);
      checks++;
      if (q != eq || r != er || dz != edz || lat != (edz ? 0 : LAT_NORM)) begin
        errors++;
        $display("FAIL rand a=%0d b=%0d got Q=%0d R=%0d dz=%0d lat=%0d want Q=%0d R=%0d dz=%0d",
                 av, bv, q, r, dz, lat, eq, er, edz);
      end
    end

    // full operand sweep, back-to-back on each IDLE
    @(posedge clk);
    d0 = done_cnt;
    for (int bi = 1; bi < 16; bi++) begin
      for (int ai = 0; ai < 256; ai++) begin
        run_op(ai, bi, q, r, dz, lat, busyc);
        ok = (ai == q * bi + r && r < bi && dz == 0 && lat == LAT_NORM) ? 1 : 0;
        checks++;
        if (ok == 0) begin
          errors++;
          $display("FAIL sweep a=%0d b=%0d got Q=%0d R=%0d dz=%0d lat=%0d need a==Q*b+R and R<b",
                   ai, bi, q, r, dz, lat);
        end
      end
    end
    @(posedge clk);
    chk("sweep_done_count", done_cnt - d0, 15 * 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
